// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V pipeline: writeback sources, load funct3 codes
// and the writeback stage state encoding.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_RSV = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment and sign/zero extension of a fetched memory word.
module load_extend (
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);
  import riscv_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // Unsupported load encodings fall through to the raw word.
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits ALU/PC+4 results one cycle after handshake and holds
// loads in WAIT_MEM until the memory data arrives, then commits the extended value.
module writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_wen,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        RegWEn,
  output logic [4:0]  rd,
  output logic [31:0] write_data,
  output logic        load_pending,
  output logic [4:0]  pending_rd,
  output logic [31:0] retire_count
);
  import riscv_pkg::*;

  wb_state_e   state_q, state_d;
  logic        regwen_q, regwen_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] retire_q, retire_d;

  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_addr_q;

  logic        hs;
  logic        is_load;
  logic        ld_capture;
  logic [31:0] ld_data;

  load_extend u_load_extend (
    .mem_rdata (mem_rdata),
    .funct3    (ld_f3_q),
    .addr_lo   (ld_addr_q),
    .data      (ld_data)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign hs       = in_valid & in_ready;
  assign is_load  = in_reg_wen && (in_wb_sel == WB_MEM);

  always_comb begin
    state_d    = state_q;
    regwen_d   = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    retire_d   = retire_q;
    ld_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // mem_rvalid is deliberately not looked at here, even in the handshake cycle.
        if (hs) begin
          if (is_load) begin
            ld_capture = 1'b1;
            state_d    = ST_WAIT_MEM;
          end else begin
            rd_d     = in_rd;
            regwen_d = in_reg_wen && (in_rd != 5'd0);
            retire_d = retire_q + 32'd1;
            case (wb_sel_e'(in_wb_sel))
              WB_ALU:  wdata_d = in_alu_result;
              WB_PC4:  wdata_d = in_pc + 32'd4;
              default: wdata_d = 32'd0;
            endcase
          end
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d  = ST_IDLE;
          rd_d     = ld_rd_q;
          regwen_d = (ld_rd_q != 5'd0);
          wdata_d  = ld_data;
          retire_d = retire_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      regwen_q <= 1'b0;
      rd_q     <= 5'd0;
      wdata_q  <= 32'd0;
      retire_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      regwen_q <= regwen_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
    end
  end

  // Held load fields need no reset: they are only observed while in WAIT_MEM.
  always_ff @(posedge clk) begin
    if (ld_capture) begin
      ld_rd_q   <= in_rd;
      ld_f3_q   <= in_funct3;
      ld_addr_q <= in_addr_lo;
    end
  end

  assign RegWEn       = regwen_q;
  assign rd           = rd_q;
  assign write_data   = wdata_q;
  assign retire_count = retire_q;
  assign load_pending = (state_q == ST_WAIT_MEM);
  assign pending_rd   = load_pending ? ld_rd_q : 5'd0;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected commits are queued at issue and
// compared when retire_count advances.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_wen;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        RegWEn;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        load_pending;
  logic [4:0]  pending_rd;
  logic [31:0] retire_count;

  writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_wen    (in_reg_wen),
    .in_rd         (in_rd),
    .in_wb_sel     (in_wb_sel),
    .in_alu_result (in_alu_result),
    .in_pc         (in_pc),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .RegWEn        (RegWEn),
    .rd            (rd),
    .write_data    (write_data),
    .load_pending  (load_pending),
    .pending_rd    (pending_rd),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_seen = 32'd0;
  logic [4:0]  prev_rd   = 5'd0;
  logic [31:0] prev_data = 32'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
    logic [31:0] sh_b, sh_h;
    sh_b = w >> (32'(a) * 8);
    sh_h = w >> (a[1] ? 16 : 0);
    if (f3 == 3'b000)      model_load = 32'($signed(sh_b[7:0]));
    else if (f3 == 3'b100) model_load = sh_b & 32'h0000_00FF;
    else if (f3 == 3'b001) model_load = 32'($signed(sh_h[15:0]));
    else if (f3 == 3'b101) model_load = sh_h & 32'h0000_FFFF;
    else                   model_load = w;
  endfunction

  // Commit monitor: a change in retire_count marks a commit.
  always @(negedge clk) begin
    if (!rst) begin
      if (retire_count !== last_seen) begin
        if (sbq.size() == 0) begin
          chk("unexpected_commit", retire_count, last_seen);
        end else begin
          mon_e = sbq.pop_front();
          chk("commit_wen", 32'(RegWEn), 32'(mon_e.wen));
          chk("commit_rd", 32'(rd), 32'(mon_e.rd));
          chk("commit_data", write_data, mon_e.data);
          chk("retire_inc", retire_count, last_seen + 32'd1);
        end
        last_seen = retire_count;
        prev_rd   = rd;
        prev_data = write_data;
      end else begin
        chk("idle_wen", 32'(RegWEn), 32'd0);
        chk("hold_rd", 32'(rd), 32'(prev_rd));
        chk("hold_data", write_data, prev_data);
      end
    end
  end

  task automatic issue(input logic wen, input logic [4:0] r, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3,
                       input logic [1:0] a, input logic [31:0] word, input int lat,
                       input logic stray);
    exp_t e;
    logic ld;
    ld     = wen && (sel == 2'd1);
    e.rd   = r;
    e.wen  = wen && (r != 5'd0);
    if (ld)              e.data = model_load(word, f3, a);
    else if (sel == 2'd0) e.data = alu;
    else if (sel == 2'd2) e.data = pc + 32'd4;
    else                  e.data = 32'd0;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    sbq.push_back(e);
    in_valid = 1'b1; in_reg_wen = wen; in_rd = r; in_wb_sel = sel;
    in_alu_result = alu; in_pc = pc; in_funct3 = f3; in_addr_lo = a;
    mem_rvalid = stray; mem_rdata = ~word;
    @(posedge clk);
    #1;
    in_valid = 1'b0; mem_rvalid = 1'b0;
    if (ld) begin
      for (int i = 0; i < lat; i++) begin
        if (i == lat - 1) begin
          mem_rvalid = 1'b1; mem_rdata = word;
        end
        @(negedge clk);
        chk("wait_ready", 32'(in_ready), 32'd0);
        chk("wait_pending", 32'(load_pending), 32'd1);
        chk("wait_pending_rd", 32'(pending_rd), 32'(r));
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  s;
    logic        w;
    logic [2:0]  f3;
    logic [2:0]  f3_tab [5];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;

    rst = 1'b1; in_valid = 1'b0; in_reg_wen = 1'b0; in_rd = 5'd0; in_wb_sel = 2'd0;
    in_alu_result = 32'd0; in_pc = 32'd0; in_funct3 = 3'd0; in_addr_lo = 2'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wen", 32'(RegWEn), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_pending_rd", 32'(pending_rd), 32'd0);
    rst = 1'b0;

    issue(1'b1, 5'd5, 2'd0, 32'h1234, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1'b0);
    issue(1'b1, 5'd7, 2'd1, 32'h0, 32'h0, 3'b000, 2'd2, 32'h0080_0000, 3, 1'b0);
    issue(1'b1, 5'd0, 2'd2, 32'h0, 32'hFFFF_FFFC, 3'd0, 2'd0, 32'h0, 0, 1'b0);
    issue(1'b1, 5'd9, 2'd1, 32'h0, 32'h0, 3'b101, 2'd3, 32'hBEEF_0000, 1, 1'b1);
    issue(1'b1, 5'd10, 2'd1, 32'h0, 32'h0, 3'b010, 2'd1, 32'hCAFE_F00D, 2, 1'b0);
    issue(1'b1, 5'd11, 2'd1, 32'h0, 32'h0, 3'b001, 2'd0, 32'h1234_8001, 1, 1'b0);
    issue(1'b1, 5'd12, 2'd1, 32'h0, 32'h0, 3'b100, 2'd3, 32'hF100_0000, 2, 1'b0);
    issue(1'b1, 5'd13, 2'd1, 32'h0, 32'h0, 3'b011, 2'd2, 32'hA5A5_5A5A, 1, 1'b0);
    issue(1'b1, 5'd0, 2'd1, 32'h0, 32'h0, 3'b000, 2'd0, 32'h0000_00FF, 1, 1'b0);
    issue(1'b1, 5'd14, 2'd3, 32'hDEAD_BEEF, 32'h100, 3'd0, 2'd0, 32'h0, 0, 1'b0);
    issue(1'b0, 5'd15, 2'd0, 32'h5555_AAAA, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      s  = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      if (!w && s == 2'd1) s = 2'd0;
      f3 = f3_tab[$urandom_range(0, 4)];
      issue(w, 5'($urandom_range(0, 31)), s, $urandom, $urandom, f3,
            2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a load.
    @(negedge clk);
    in_valid = 1'b1; in_reg_wen = 1'b1; in_rd = 5'd9; in_wb_sel = 2'd1;
    in_funct3 = 3'b010; in_addr_lo = 2'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midld_pending", 32'(load_pending), 32'd1);
    chk("midld_pending_rd", 32'(pending_rd), 32'd9);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_wen", 32'(RegWEn), 32'd0);
    chk("midrst_rd", 32'(rd), 32'd0);
    chk("midrst_data", write_data, 32'd0);
    chk("midrst_retire", retire_count, 32'd0);
    chk("midrst_pending", 32'(load_pending), 32'd0);
    chk("midrst_pending_rd", 32'(pending_rd), 32'd0);
    sbq.delete();
    last_seen = 32'd0; prev_rd = 5'd0; prev_data = 32'd0;
    #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    repeat (2) begin
      @(negedge clk);
      chk("stray_rvalid_retire", retire_count, 32'd0);
      chk("stray_rvalid_wen", 32'(RegWEn), 32'd0);
    end
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;

    // Counter wrap.
    @(negedge clk);
    #1;
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    last_seen = 32'hFFFF_FFFF;
    chk("wrap_preload", retire_count, 32'hFFFF_FFFF);
    issue(1'b1, 5'd3, 2'd0, 32'h7777_0001, 32'h0, 3'd0, 2'd0, 32'h0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_zero", retire_count, 32'd0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
